// File: rtl/x_scale_coef_fetch.sv
// Horizontal-scaler coefficient fetcher: walks the coefficient ROM for one output line
// and presents {src_x, frac, col, last} words through a 2-entry valid/ready buffer.
module x_scale_coef_fetch #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 15,
    parameter int FRAC_W     = 4
) (
    input  logic                         clk,
    input  logic                         tb_rst,
    input  logic                         line_start,
    input  logic [ADDR_WIDTH-1:0]        out_width,
    input  logic                         abort,
    output logic [ADDR_WIDTH-1:0]        rom_addr,
    input  logic [DATA_WIDTH-1:0]        rom_data,
    output logic                         coef_valid,
    input  logic                         coef_ready,
    output logic [DATA_WIDTH-FRAC_W-1:0] src_x,
    output logic [FRAC_W-1:0]            frac,
    output logic [ADDR_WIDTH-1:0]        col,
    output logic                         last,
    output logic                         busy,
    output logic                         line_done,
    output logic [1:0]                   state_dbg
);

    // Handshake: a word transfers on every rising edge where coef_valid && coef_ready;
    // while coef_valid is high and coef_ready low, the presented word is held unchanged.

    localparam int EW = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] width_q;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic                  inflight;
    logic                  zero_done;
    logic [EW-1:0]         fifo_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            fifo_count;
    logic [2:0]            occ_after_pop;
    logic                  pop;
    logic                  issue;
    logic [EW-1:0]         push_word;

    assign last_idx      = width_q - ONE;
    assign coef_valid    = (fifo_count != 2'd0);
    assign pop           = coef_valid && coef_ready;
    // Words already buffered or on their way, minus the one leaving this cycle.
    assign occ_after_pop = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue         = (state == FETCH) && (occ_after_pop < 3'd2);
    // rom_addr still holds the address whose data is on rom_data this cycle.
    assign push_word     = {rom_data, rom_addr, (rom_addr == last_idx)};

    assign {src_x, frac, col, last} = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE);
    assign line_done = zero_done | (pop && last && !abort);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state      <= IDLE;
            width_q    <= '0;
            cnt        <= '0;
            rom_addr   <= '0;
            inflight   <= 1'b0;
            zero_done  <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
        end else if (abort) begin
            state      <= IDLE;
            cnt        <= '0;
            inflight   <= 1'b0;
            zero_done  <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            zero_done <= 1'b0;
            if (inflight) begin
                fifo_mem[wr_ptr] <= push_word;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
            inflight   <= issue;
            if (issue) begin
                rom_addr <= cnt;
                cnt      <= cnt + ONE;
            end
            case (state)
                IDLE: begin
                    if (line_start) begin
                        if (out_width != '0) begin
                            width_q <= out_width;
                            cnt     <= '0;
                            state   <= FETCH;
                        end else begin
                            zero_done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue && (cnt == last_idx)) state <= DRAIN;
                end
                DRAIN: begin
                    if ((fifo_count == 2'd0) && !inflight) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x_scale_coef_fetch.sv
// Scoreboard bench for x_scale_coef_fetch: a ROM table drives rom_data, a line model
// predicts every word, and a negedge monitor checks each handshake.
module tb_x_scale_coef_fetch;

    localparam int AW = 11;
    localparam int DW = 15;
    localparam int FW = 4;
    localparam int EW = DW + AW + 1;

    logic            clk;
    logic            tb_rst;
    logic            line_start;
    logic [AW-1:0]   out_width;
    logic            abort;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic            coef_valid;
    logic            coef_ready;
    logic [DW-FW-1:0] src_x;
    logic [FW-1:0]   frac;
    logic [AW-1:0]   col;
    logic            last;
    logic            busy;
    logic            line_done;
    logic [1:0]      state_dbg;

    x_scale_coef_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAC_W(FW)) dut (
        .clk(clk), .tb_rst(tb_rst), .line_start(line_start), .out_width(out_width),
        .abort(abort), .rom_addr(rom_addr), .rom_data(rom_data), .coef_valid(coef_valid),
        .coef_ready(coef_ready), .src_x(src_x), .frac(frac), .col(col), .last(last),
        .busy(busy), .line_done(line_done), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM: data follows rom_addr, so it is valid the cycle after an issue.
    logic [DW-1:0] rom [0:(1<<AW)-1];
    assign rom_data = rom[rom_addr];

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int got_done = 0;
    int exp_done = 0;
    int rdy_mode = 1;  // 0 hold low, 1 always high, 2 toggle, 3 random
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       coef_ready = 1'b0;
            1:       coef_ready = 1'b1;
            2:       coef_ready = ~coef_ready;
            default: coef_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic fill_rom(input bit formula);
        logic [DW-FW-1:0] sx;
        logic [FW-1:0]    fr;
        for (int k = 0; k < (1 << AW); k++) begin
            if (formula) begin
                sx = 11'(k + 3);
                fr = 4'(k);
                rom[k] = {sx, fr};
            end else begin
                rom[k] = 15'($urandom_range(0, 32767));
            end
        end
    endtask

    // Model: a line of width w yields ROM words 0..w-1 in order, tagged with their column.
    task automatic start_line(input int w);
        logic [AW-1:0] c_tag;
        @(posedge clk); #1;
        line_start = 1'b1;
        out_width  = 11'(w);
        exp_done++;
        for (int c = 0; c < w; c++) begin
            c_tag = 11'(c);
            exp_q.push_back({rom[c], c_tag, (c == w - 1)});
        end
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || coef_valid || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("line_completes", 32'(n < budget), 32'(1));
        check("queue_drained", 32'(exp_q.size()), 32'(0));
    endtask

    // ---------------- scoreboard monitor ----------------
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_out;
    always @(negedge clk) begin
        logic [EW-1:0] cur;
        logic [EW-1:0] e;
        cur = {src_x, frac, col, last};
        if (tb_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(coef_valid), 32'(1));
                check("stall_hold", 32'(cur), 32'(prev_out));
            end
            if (coef_valid && coef_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 32'(cur), 32'(e));
                    check("line_done_on_pop", 32'(line_done), 32'(e[0]));
                end
                pops++;
            end
            if (line_done) got_done++;
            prev_stall = coef_valid && !coef_ready;
            prev_out   = cur;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        tb_rst     = 1'b1;
        line_start = 1'b0;
        abort      = 1'b0;
        out_width  = '0;
        coef_ready = 1'b0;
        fill_rom(1'b1);
        @(posedge clk);
        @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'(0));
        check("rst_valid", 32'(coef_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(line_done), 32'(0));
        check("rst_head", 32'({src_x, frac, col, last}), 32'(0));
        check("rst_state", 32'(state_dbg), 32'(0));
        @(posedge clk); #1;
        tb_rst = 1'b0;

        // Back-to-back line, ROM word k = {k+3, k[3:0]}.
        rdy_mode = 1;
        start_line(8);
        @(negedge clk);
        check("lat_c1_busy", 32'(busy), 32'(1));
        check("lat_c1_valid", 32'(coef_valid), 32'(0));
        @(negedge clk);
        check("lat_c2_valid", 32'(coef_valid), 32'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stream_valid", 32'(coef_valid), 32'(1));
            check("stream_col", 32'(col), 32'(i));
            check("stream_src_x", 32'(src_x), 32'(i + 3));
            check("stream_last", 32'(last), 32'(i == 7));
        end
        wait_idle(20);

        // Toggling ready.
        fill_rom(1'b0);
        rdy_mode = 2;
        start_line(6);
        wait_idle(60);

        // Long stall: buffer fills with cols 0,1 and issuing stops.
        rdy_mode = 0;
        start_line(4);
        repeat (10) @(posedge clk);
        #1;
        check("stall_rom_addr", 32'(rom_addr), 32'(1));
        check("stall_head_col", 32'(col), 32'(0));
        check("stall_valid_hi", 32'(coef_valid), 32'(1));
        rdy_mode = 1;
        wait_idle(30);

        // Zero-width line.
        start_line(0);
        @(negedge clk);
        check("zero_done", 32'(line_done), 32'(1));
        for (int i = 0; i < 3; i++) begin
            check("zero_busy", 32'(busy), 32'(0));
            check("zero_valid", 32'(coef_valid), 32'(0));
            @(negedge clk);
        end
        wait_idle(5);

        // Abort after 5 pops, then a fresh short line.
        start_line(16);
        base = pops;
        n = 0;
        while (pops - base < 5 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("abort_reach", 32'(n < 40), 32'(1));
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        exp_done--;
        @(negedge clk);
        check("abort_valid", 32'(coef_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(line_done), 32'(0));
        start_line(3);
        wait_idle(30);

        // Reset mid-line while a word is presented.
        rdy_mode = 0;
        start_line(8);
        n = 0;
        while (!coef_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("pre_reset_valid", 32'(coef_valid), 32'(1));
        #1;
        tb_rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(coef_valid), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_rom_addr", 32'(rom_addr), 32'(0));
        check("mid_rst_head", 32'({src_x, frac, col, last}), 32'(0));
        check("mid_rst_done", 32'(line_done), 32'(0));
        exp_q.delete();
        exp_done--;
        @(posedge clk);
        @(posedge clk); #1;
        tb_rst = 1'b0;
        rdy_mode = 1;
        fill_rom(1'b0);
        start_line(5);
        wait_idle(30);

        // Randomized lines under random backpressure.
        rdy_mode = 3;
        for (int l = 0; l < 8; l++) begin
            fill_rom(1'b0);
            start_line($urandom_range(0, 24));
            wait_idle(200);
        end

        // Maximum width: counter must stop exactly at the last column.
        rdy_mode = 1;
        start_line((1 << AW) - 1);
        wait_idle(2200);
        check("max_last_addr", 32'(rom_addr), 32'((1 << AW) - 2));

        repeat (3) @(posedge clk);
        check("done_count", 32'(got_done), 32'(exp_done));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/x_scale_coef_fetch.md
X_SCALE_COEF_FETCH -- requirements
Module: x_scale_coef_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, coefficient ROM address width and output-column counter width.
REQ-002 Parameter DATA_WIDTH, default 15, coefficient ROM word width.
REQ-003 Parameter FRAC_W, default 4, fractional-weight field width; integer field is DATA_WIDTH-FRAC_W bits.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 tb_rst  input  1  reset, asynchronous, active-high.
REQ-006 line_start  input  1  single-cycle pulse starting one output line.
REQ-007 out_width  input  ADDR_WIDTH  number of output columns for the line; sampled on accepted line_start.
REQ-008 abort  input  1  synchronous flush of the current line.
REQ-009 rom_addr  output  ADDR_WIDTH  address to the coefficient ROM (registered).
REQ-010 rom_data  input  DATA_WIDTH  ROM read data, valid exactly 1 cycle after rom_addr changes (no output register).
REQ-011 coef_valid  output  1  coefficient word available downstream.
REQ-012 coef_ready  input  1  downstream accepts the word.
REQ-013 src_x  output  DATA_WIDTH-FRAC_W  integer source column, rom_data[DATA_WIDTH-1:FRAC_W].
REQ-014 frac  output  FRAC_W  interpolation weight, rom_data[FRAC_W-1:0].
REQ-015 col  output  ADDR_WIDTH  output column index of the presented word.
REQ-016 last  output  1  presented word is column out_width-1.
REQ-017 busy  output  1  line in progress (state != IDLE).
REQ-018 line_done  output  1  single-cycle pulse when the line's final word has been accepted.

Function
REQ-019 FSM states IDLE, FETCH, DRAIN.
REQ-020 IDLE: line_start with out_width!=0 -> latch width, issue counter=0, go FETCH next cycle.
REQ-021 IDLE: line_start with out_width==0 -> line_done pulse next cycle, stay IDLE, no ROM issue, no coef_valid.
REQ-022 line_start while busy=1 is ignored; latched width unchanged.
REQ-023 Output buffer: 2-entry FIFO holding {src_x, frac, col, last}.
REQ-024 Issue rule: in FETCH, issue address N (rom_addr<=N, inflight<=1) only when fifo_count + inflight - pop_this_cycle < 2; counter increments per issue.
REQ-025 Capture: cycle after an issue, rom_data pushed into FIFO with tag col=N, last=(N==width-1); inflight clears unless a new issue occurs.
REQ-026 rom_addr holds its last value when not issuing.
REQ-027 After issuing column width-1, FETCH -> DRAIN.
REQ-028 DRAIN -> IDLE when FIFO empty and inflight=0; line_done pulses in the cycle the last word is popped.
REQ-029 coef_valid = FIFO non-empty; outputs show FIFO head; pop on coef_valid && coef_ready.
REQ-030 While coef_valid && !coef_ready, src_x, frac, col, last stable.
REQ-031 Simultaneous push and pop on a FIFO holding 1 entry: count stays 1, head advances correctly.
REQ-032 Latency: with coef_ready=1, first coef_valid 3 cycles after line_start cycle (IDLE->FETCH, issue, capture); throughput 1 word/cycle thereafter.
REQ-033 Column counter compares full width; out_width=2**ADDR_WIDTH-1 max; no wrap past width-1.
REQ-034 abort (any state): next cycle FIFO empty, inflight=0, coef_valid=0, state IDLE, no line_done; abort has priority over line_start in the same cycle.

Reset
REQ-035 tb_rst=1: state IDLE, rom_addr=0, counter=0, inflight=0, FIFO empty, coef_valid=0, col=0, last=0, src_x=0, frac=0, busy=0, line_done=0.
REQ-036 Reset mid-line discards all state; no line_done; line_start is accepted on the first clock after release.

Verification
REQ-037 out_width=8, coef_ready=1, ROM word k = {k+3, k[3:0]} -> coef_valid 3 cycles after line_start, 8 consecutive words col 0..7, src_x=3..10, last only on col 7, line_done same cycle as col 7 pop.
REQ-038 out_width=6, coef_ready toggling 1/0 each cycle -> 6 words in order, no duplicates/drops, outputs stable while stalled, issue never exceeds FIFO capacity.
REQ-039 out_width=4, coef_ready=0 for 10 cycles then 1 -> FIFO holds col 0,1, rom_addr stalls at 1, then cols 0..3 delivered, line_done once.
REQ-040 out_width=0 -> line_done 1 cycle after line_start, coef_valid never asserted, busy stays 0.
REQ-041 out_width=16, abort asserted after 5 pops -> next cycle coef_valid=0, busy=0, no line_done; new line_start with out_width=3 delivers cols 0..2.
REQ-042 tb_rst asserted mid-line with coef_valid=1 -> all outputs at REQ-035 values immediately; line_start after release runs a full line normally.
